elastic_pipe: RTL and testbench
===============================

// Module: elastic_pipe
// PURPOSE
//  Valid/ready controller and datapath for a depth_p-stage pipeline of inelastic registers.
//  Tracks per-stage valid bits and drives each stage's en_i.
//  Bubbles collapse: an empty stage accepts data even while downstream is stalled.
//  Used ahead of the CDC FIFO write port to retime and buffer producer data.
// PARAMETERS
//  width_p           8  data width in bits (>=1)
//  depth_p           3  number of register stages (>=1)
//  datapath_reset_p  0  1: data regs clear to 0 on reset_i; 0: data regs hold on reset_i
// PORTS
//  clk_i    in   1                     clock, all state on posedge
//  reset_i  in   1                     synchronous, active-high reset
//  valid_i  in   1                     producer data valid
//  ready_o  out  1                     pipe accepts data_i this cycle
//  data_i   in   width_p               producer data
//  valid_o  out  1                     stage depth_p-1 holds valid data
//  ready_i  in   1                     consumer accepts data_o this cycle
//  data_o   out  width_p               stage depth_p-1 data
//  count_o  out  $clog2(depth_p+1)     number of valid stages
// BEHAVIOUR
//  - Stage k: data register = one inelastic instance (width_p, datapath_reset_p); valid bit v[k].
//  - Stage readiness, combinational, last stage to first:
//      rdy[depth_p-1] = ~v[depth_p-1] | ready_i
//      rdy[k]         = ~v[k] | rdy[k+1]
//  - ready_o = rdy[0]. This is a combinational path from ready_i; there is no registered skid.
//  - Source valid into stage k: src[0] = valid_i; src[k] = v[k-1].
//  - Stage enable: en[k] = rdy[k] & src[k]. The stage loads data from stage k-1 (or from data_i when k=0).
//  - Valid update when rdy[k]=1: v[k] <= src[k]. When rdy[k]=0: v[k] holds.
//  - valid_o = v[depth_p-1]; data_o = data of stage depth_p-1.
//  - Input handshake: a word transfers in when valid_i & ready_o.
//  - Output handshake: a word transfers out when valid_o & ready_i.
//  - Producer rules:
//      - valid_i may be asserted independent of ready_o.
//      - data_i must stay stable while valid_i=1 and ready_o=0.
//  - data_o is stable while valid_o=1 and ready_i=0. No word is dropped, duplicated or reordered.
//  - Latency: with ready_i held 1, a word accepted at cycle t has valid_o=1 at cycle t+depth_p.
//  - Throughput: 1 word/cycle with ready_i=1.
//  - Full (count_o=depth_p):
//      - ready_o = ready_i.
//      - Simultaneous accept and emit is legal; count_o is unchanged.
//  - Empty (count_o=0): valid_o=0 and ready_o=1, regardless of ready_i.
//  - count_o next value = count_o + in_xfer - out_xfer. count_o never exceeds depth_p.
//  - Reset (any cycle, including mid-transfer):
//      - All v[k] <= 0 and count_o <= 0. In-flight words are discarded.
//      - Data regs clear to 0 only if datapath_reset_p=1.
//      - During reset_i=1: valid_o=0, ready_o=1, and no handshake counts.
//  - depth_p=1: a single stage with rdy[0] = ~v[0] | ready_i.
// TESTING
//  1. Reset, then stream 0x01..0x10 with ready_i=1 and depth_p=3.
//     -> First valid_o 3 cycles after the first accept; data_o is 0x01..0x10 in order, 1/cycle.
//  2. Hold ready_i=0 and drive valid_i=1 with 0xA0,0xA1,0xA2,0xA3.
//     -> 3 accepted, ready_o=0 after the 3rd, count_o=3.
//     -> Release ready_i: 0xA0,0xA1,0xA2 out, then 0xA3 accepted and emitted.
//  3. Full pipe with ready_i=1 and valid_i=1 in the same cycle.
//     -> One in and one out; count_o stays 3; no bubble inserted.
//  4. Bubble collapse: load 0x55, stall ready_i=0 until it reaches the last stage, then send 0x66.
//     -> 0x66 advances to stage 1 behind 0x55; count_o=2.
//  5. Assert reset_i with count_o=2 mid-stream.
//     -> Next cycle valid_o=0, count_o=0, ready_o=1.
//     -> data_o=0 if datapath_reset_p=1, else unchanged.
//  6. Random valid_i/ready_i for 10k cycles vs. a queue scoreboard.
//     -> No loss, duplication or reorder; count_o matches the model; data_o is stable under stall.

Source files
------------

// File: rtl/elastic_pipe.sv
// Valid/ready controlled pipeline of inelastic register stages.
// Each stage tracks a valid bit. An empty stage accepts data even when the stage
// after it is stalled, so bubbles collapse. ready_o is a purely combinational
// function of ready_i and the valid bits. There is no skid buffer.

// One inelastic data register. It loads on en_i.
// It optionally clears to zero on reset.
module inelastic_reg #(
  parameter int width_p = 8,
  parameter int reset_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;
  logic [width_p-1:0] data_d;

  // Next data value: load when enabled, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = data_i;
    end
  end

  // Data register. Clearing on reset is optional so the datapath can stay reset-free.
  always_ff @(posedge clk_i) begin
    if (reset_i && (reset_p != 0)) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

module elastic_pipe #(
  parameter int width_p          = 8,
  parameter int depth_p          = 3,
  parameter int datapath_reset_p = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [width_p-1:0]           data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [width_p-1:0]           data_o,
  output logic [$clog2(depth_p+1)-1:0] count_o
);

  localparam int count_w_lp = $clog2(depth_p+1);

  logic [depth_p-1:0]    v_q;
  logic [depth_p-1:0]    v_d;
  logic [depth_p-1:0]    rdy;
  logic [depth_p-1:0]    src;
  logic [depth_p-1:0]    en;
  logic                  rdy_chain;
  logic [count_w_lp-1:0] count_q;
  logic [count_w_lp-1:0] count_d;
  logic                  in_xfer;
  logic                  out_xfer;
  logic [width_p-1:0]    stage_data [depth_p];

  // Readiness ripples from the consumer backwards.
  // A stage can take a word if it is empty or if its own word moves on this cycle.
  always_comb begin
    rdy       = '0;
    rdy_chain = ready_i;
    for (int k = depth_p - 1; k >= 0; k--) begin
      rdy_chain = ~v_q[k] | rdy_chain;
      rdy[k]    = rdy_chain;
    end
  end

  // Source valids and next valid bits.
  // A ready stage takes whatever its source offers, and a stalled stage keeps its word.
  always_comb begin
    src    = '0;
    src[0] = valid_i;
    for (int k = 1; k < depth_p; k++) begin
      src[k] = v_q[k-1];
    end
    v_d = (rdy & src) | (~rdy & v_q);
  end

  assign en       = rdy & src & {depth_p{~reset_i}};
  assign ready_o  = rdy[0] | reset_i;
  assign valid_o  = v_q[depth_p-1] & ~reset_i;
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;
  assign data_o   = stage_data[depth_p-1];
  assign count_o  = count_q;

  // Occupancy count: one is added per accepted word and one is subtracted per emitted word.
  always_comb begin
    count_d = count_q + count_w_lp'(in_xfer) - count_w_lp'(out_xfer);
  end

  // Valid bits and occupancy count. Reset discards every in-flight word.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
    end
  end

  for (genvar k = 0; k < depth_p; k++) begin : g_stage
    logic [width_p-1:0] stage_in;
    if (k == 0) begin : g_first
      assign stage_in = data_i;
    end else begin : g_rest
      assign stage_in = stage_data[k-1];
    end
    inelastic_reg #(
      .width_p (width_p),
      .reset_p (datapath_reset_p)
    ) u_reg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (en[k]),
      .data_i  (stage_in),
      .data_o  (stage_data[k])
    );
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Self-checking bench for elastic_pipe (depth 3, width 8).
// The bench runs directed scenarios followed by a long random run.
// The reference model keeps the in-flight words as a queue of (data, stage position).
// It advances every word each cycle as far as the word ahead of it allows.
module tb_elastic_pipe;

  localparam int W = 8;
  localparam int D = 3;

  typedef struct {
    logic [W-1:0] d;
    int           p;
  } entry_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         validIn = 1'b0;
  logic         readyIn = 1'b0;
  logic [W-1:0] dataIn = '0;
  logic         readyOut;
  logic         validOut;
  logic [W-1:0] dataOut;
  logic [1:0]   countOut;
  logic         readyOutR;
  logic         validOutR;
  logic [W-1:0] dataOutR;
  logic [1:0]   countOutR;

  int checks = 0;
  int errors = 0;
  entry_t pipeQ[$];
  logic lastReadyO;
  logic lastValidO;

  always #5 clk = ~clk;

  elastic_pipe #(.width_p(W), .depth_p(D), .datapath_reset_p(0)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .valid_i (validIn),
    .ready_o (readyOut),
    .data_i  (dataIn),
    .valid_o (validOut),
    .ready_i (readyIn),
    .data_o  (dataOut),
    .count_o (countOut)
  );

  elastic_pipe #(.width_p(W), .depth_p(D), .datapath_reset_p(1)) dutR (
    .clk_i   (clk),
    .reset_i (reset),
    .valid_i (validIn),
    .ready_o (readyOutR),
    .data_i  (dataIn),
    .valid_o (validOutR),
    .ready_i (readyIn),
    .data_o  (dataOutR),
    .count_o (countOutR)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the inputs, predict the outputs from the model, compare them, then advance the model.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r);
    entry_t newQ[$];
    int     prevNew;
    int     np;
    logic   expReady;
    logic   expValid;
    logic [W-1:0] expData;
    @(posedge clk);
    #1;
    validIn = v;
    dataIn  = d;
    readyIn = r;
    expValid = (pipeQ.size() > 0) && (pipeQ[0].p == D - 1);
    expData  = expValid ? pipeQ[0].d : '0;
    prevNew  = D;
    for (int i = 0; i < pipeQ.size(); i++) begin
      if (i == 0 && pipeQ[i].p == D - 1 && r) begin
        continue;
      end
      np = (pipeQ[i].p + 1 < prevNew) ? pipeQ[i].p + 1 : pipeQ[i].p;
      newQ.push_back('{d: pipeQ[i].d, p: np});
      prevNew = np;
    end
    expReady = 1'b1;
    foreach (newQ[i]) begin
      if (newQ[i].p == 0) expReady = 1'b0;
    end
    @(negedge clk);
    checkOutput("ready_o", {31'd0, readyOut}, {31'd0, expReady});
    checkOutput("valid_o", {31'd0, validOut}, {31'd0, expValid});
    checkOutput("count_o", {30'd0, countOut}, pipeQ.size());
    if (expValid) checkOutput("data_o", {24'd0, dataOut}, {24'd0, expData});
    lastReadyO = readyOut;
    lastValidO = validOut;
    if (v && expReady) newQ.push_back('{d: d, p: 0});
    pipeQ = newQ;
  endtask

  // Reset for one cycle with a transfer attempt pending. This checks the outputs while reset is held.
  task automatic doReset(input logic v, input logic r);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    validIn = v;
    readyIn = r;
    dataIn  = 8'hEE;
    @(negedge clk);
    checkOutput("rst_valid_o", {31'd0, validOut}, 32'd0);
    checkOutput("rst_ready_o", {31'd0, readyOut}, 32'd1);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    validIn = 1'b0;
    readyIn = 1'b0;
    pipeQ.delete();
  endtask

  initial begin
    int  firstValid;
    int  numOut;
    logic pendV;
    logic [W-1:0] pendD;
    logic v;
    logic r;
    logic [W-1:0] d;
    logic accepted;

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("init_count", {30'd0, countOut}, 32'd0);
    checkOutput("init_valid", {31'd0, validOut}, 32'd0);
    checkOutput("init_ready", {31'd0, readyOut}, 32'd1);

    // Stream 0x01..0x10 with the consumer always ready.
    firstValid = -1;
    numOut = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i < 16, (i < 16) ? W'(i + 1) : '0, 1'b1);
      if (lastValidO) numOut++;
      if (lastValidO && firstValid < 0) firstValid = i;
    end
    checkOutput("t1_latency", firstValid, 32'd3);
    checkOutput("t1_words_out", numOut, 32'd16);

    // Stalled consumer: three words fill the pipe and the fourth waits.
    applyStimulus(1'b1, 8'hA0, 1'b0);
    applyStimulus(1'b1, 8'hA1, 1'b0);
    applyStimulus(1'b1, 8'hA2, 1'b0);
    applyStimulus(1'b1, 8'hA3, 1'b0);
    checkOutput("t2_full_ready", {31'd0, lastReadyO}, 32'd0);
    checkOutput("t2_full_count", {30'd0, countOut}, 32'd3);
    accepted = 1'b0;
    for (int i = 0; i < 5 && !accepted; i++) begin
      applyStimulus(1'b1, 8'hA3, 1'b1);
      accepted = lastReadyO;
    end
    checkOutput("t2_a3_accepted", {31'd0, accepted}, 32'd1);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1);

    // Full pipe with simultaneous accept and emit.
    applyStimulus(1'b1, 8'hB0, 1'b0);
    applyStimulus(1'b1, 8'hB1, 1'b0);
    applyStimulus(1'b1, 8'hB2, 1'b0);
    applyStimulus(1'b1, 8'hB3, 1'b1);
    checkOutput("t3_through_ready", {31'd0, lastReadyO}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t3_count_kept", {30'd0, countOut}, 32'd3);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1);

    // Bubble collapse: 0x66 closes up behind a stalled 0x55.
    applyStimulus(1'b1, 8'h55, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b0);
    checkOutput("t4_accept_while_stalled", {31'd0, lastReadyO}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t4_count", {30'd0, countOut}, 32'd2);
    checkOutput("t4_data", {24'd0, dataOut}, 32'h55);

    // Mid-stream reset discards the words. Only the clearing variant zeros its data.
    doReset(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t5_count", {30'd0, countOut}, 32'd0);
    checkOutput("t5_valid", {31'd0, validOut}, 32'd0);
    checkOutput("t5_ready", {31'd0, readyOut}, 32'd1);
    checkOutput("t5_data_held", {24'd0, dataOut}, 32'h55);
    checkOutput("t5_data_cleared", {24'd0, dataOutR}, 32'd0);
    checkOutput("t5_count_r", {30'd0, countOutR}, 32'd0);

    // Random traffic. The producer holds its word steady until it is accepted.
    pendV = 1'b0;
    pendD = '0;
    for (int i = 0; i < 10000; i++) begin
      if (pendV) begin
        v = 1'b1;
        d = pendD;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = W'($urandom);
      end
      r = ($urandom_range(0, 3) != 0);
      applyStimulus(v, d, r);
      pendV = v && !lastReadyO;
      pendD = d;
    end
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t6_drained", {30'd0, countOut}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
